// File: rtl/round_robin_fifo_distributor.sv
// Deals one write stream round-robin over four channel FIFOs with independent readers.
// Optional RR_DIST_SKIP_FULL_EN: a write skips full channels instead of being rejected.
module round_robin_fifo_distributor #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wen,
    input  logic [DATA_W-1:0]   din,
    input  logic [3:0]          ren,
    output logic [4*DATA_W-1:0] dout,
    output logic [3:0]          valid,
    output logic [3:0]          rerr,
    output logic                werr,
    output logic [3:0]          full,
    output logic [3:0]          empty,
    output logic [1:0]          ptr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [4][DEPTH];
    logic [AW-1:0]     head [4];
    logic [AW-1:0]     tail [4];
    logic [CW-1:0]     cnt  [4];

    logic [1:0] target;
    logic [1:0] idx;
    logic       wr_ok;
    logic       wr_go;
    logic [3:0] wsel;
    logic [3:0] rd_go;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i]  = (cnt[i] == CW'(DEPTH));
            empty[i] = (cnt[i] == '0);
        end
    end

    always_comb begin
        target = ptr;
        idx    = ptr;
        wr_ok  = 1'b0;
`ifdef RR_DIST_SKIP_FULL_EN
        // Scan downward so the nearest non-full channel from ptr wins.
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (!full[idx]) begin
                target = idx;
                wr_ok  = 1'b1;
            end
        end
`else
        wr_ok = !full[ptr];
`endif
        wr_go = wen & wr_ok;
        for (int i = 0; i < 4; i++) begin
            wsel[i]  = wr_go && (target == 2'(i));
            rd_go[i] = ren[i] & !empty[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_n && wsel[i]) begin
                mem[i][tail[i]] <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= '0;
            werr  <= 1'b0;
            dout  <= '0;
            valid <= '0;
            rerr  <= '0;
            for (int i = 0; i < 4; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            werr <= wen & !wr_ok;
            if (wr_go) begin
                ptr <= target + 2'd1;
            end
            for (int i = 0; i < 4; i++) begin
                if (wsel[i]) begin
                    tail[i] <= tail[i] + AW'(1);
                end
                if (rd_go[i]) begin
                    head[i] <= head[i] + AW'(1);
                end
                cnt[i]   <= cnt[i] + CW'(wsel[i]) - CW'(rd_go[i]);
                valid[i] <= rd_go[i];
                rerr[i]  <= ren[i] & empty[i];
                dout[i*DATA_W +: DATA_W] <= rd_go[i] ? mem[i][head[i]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_fifo_distributor.sv
// Directed bench for round_robin_fifo_distributor; honours RR_DIST_SKIP_FULL_EN.
module tb_round_robin_fifo_distributor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [7:0]  din;
    logic [3:0]  ren;
    logic [31:0] dout;
    logic [3:0]  valid;
    logic [3:0]  rerr;
    logic        werr;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [1:0]  ptr;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic        wen;
        logic [7:0]  din;
        logic [3:0]  ren;
        logic [31:0] dout;
        logic [3:0]  valid;
        logic [3:0]  rerr;
        logic        werr;
        logic [3:0]  full;
        logic [3:0]  empty;
        logic [1:0]  ptr;
    } vec_t;

    vec_t tbl [11];

    round_robin_fifo_distributor #(.DATA_W(8), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (wen),
        .din   (din),
        .ren   (ren),
        .dout  (dout),
        .valid (valid),
        .rerr  (rerr),
        .werr  (werr),
        .full  (full),
        .empty (empty),
        .ptr   (ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [7:0] d,
                        input logic [3:0] rn);
        @(negedge clk);
        rst_n = r;
        wen   = w;
        din   = d;
        ren   = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".dout"},  dout,  v.dout);
        chk({tag, ".valid"}, 32'(valid), 32'(v.valid));
        chk({tag, ".rerr"},  32'(rerr),  32'(v.rerr));
        chk({tag, ".werr"},  32'(werr),  32'(v.werr));
        chk({tag, ".full"},  32'(full),  32'(v.full));
        chk({tag, ".empty"}, 32'(empty), 32'(v.empty));
        chk({tag, ".ptr"},   32'(ptr),   32'(v.ptr));
    endtask

    initial begin
        rst_n = 1'b0;
        wen   = 1'b0;
        din   = '0;
        ren   = '0;

        //         rst  wen din    ren   dout          val   rerr  werr full  empty ptr
        tbl[0]  = '{1'b0, 1'b1, 8'h99, 4'hf, 32'h0,        4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 2'd0};
        tbl[1]  = '{1'b1, 1'b1, 8'h11, 4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 4'h0, 4'he, 2'd1};
        tbl[2]  = '{1'b1, 1'b1, 8'h22, 4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 4'h0, 4'hc, 2'd2};
        tbl[3]  = '{1'b1, 1'b1, 8'h33, 4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 4'h0, 4'h8, 2'd3};
        tbl[4]  = '{1'b1, 1'b1, 8'h44, 4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 2'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 4'hf, 32'h44332211, 4'hf, 4'h0, 1'b0, 4'h0, 4'hf, 2'd0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 2'd0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 4'h4, 32'h0,        4'h0, 4'h4, 1'b0, 4'h0, 4'hf, 2'd0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 4'h0, 32'h0,        4'h0, 4'h0, 1'b0, 4'h0, 4'hf, 2'd0};
        tbl[9]  = '{1'b1, 1'b1, 8'h5a, 4'h1, 32'h0,        4'h0, 4'h1, 1'b0, 4'h0, 4'he, 2'd1};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 4'h1, 32'h0000005a, 4'h1, 4'h0, 1'b0, 4'h0, 4'hf, 2'd1};

        step(1'b0, 1'b0, 8'h00, 4'h0);
        step(1'b0, 1'b0, 8'h00, 4'h0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst_n, tbl[i].wen, tbl[i].din, tbl[i].ren);
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Fill all four channels, then overflow.
        step(1'b0, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 8'(i), 4'h0);
            chk($sformatf("fill%0d.werr", i), 32'(werr), 32'h0);
        end
        chk("fill.full", 32'(full), 32'hf);
        chk("fill.ptr", 32'(ptr), 32'h0);
        step(1'b1, 1'b1, 8'haa, 4'h0);
        chk("ovf.werr", 32'(werr), 32'h1);
        chk("ovf.ptr", 32'(ptr), 32'h0);
        chk("ovf.full", 32'(full), 32'hf);
        step(1'b1, 1'b0, 8'h00, 4'h0);
        chk("ovf.werr_clr", 32'(werr), 32'h0);

        // Free one slot in channel 1, then write with ptr at full channel 0.
        step(1'b1, 1'b0, 8'h00, 4'h2);
        chk("skip.rd_dout", dout, 32'h00000100);
        chk("skip.rd_valid", 32'(valid), 32'h2);
        step(1'b1, 1'b1, 8'haa, 4'h0);
`ifdef RR_DIST_SKIP_FULL_EN
        chk("skip.werr", 32'(werr), 32'h0);
        chk("skip.ptr", 32'(ptr), 32'h2);
        chk("skip.full", 32'(full), 32'hf);
`else
        chk("skip.werr", 32'(werr), 32'h1);
        chk("skip.ptr", 32'(ptr), 32'h0);
        chk("skip.full", 32'(full), 32'hd);
`endif

        // Same-edge read and write on full channel 0.
        step(1'b1, 1'b1, 8'h55, 4'h1);
        chk("simul.dout", dout, 32'h0);
        chk("simul.valid", 32'(valid), 32'h1);
        chk("simul.werr", 32'(werr), 32'h1);
        chk("simul.full0", 32'(full[0]), 32'h0);
`ifdef RR_DIST_SKIP_FULL_EN
        chk("simul.ptr", 32'(ptr), 32'h2);
`else
        chk("simul.ptr", 32'(ptr), 32'h0);
`endif

        // Drain channel 0: seven entries 4..28 remain.
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b0, 8'h00, 4'h1);
            chk($sformatf("ch0rd%0d.dout", k), dout, 32'(4 * k));
            chk($sformatf("ch0rd%0d.valid", k), 32'(valid), 32'h1);
        end
        step(1'b1, 1'b0, 8'h00, 4'h1);
        chk("ch0rd8.rerr", 32'(rerr), 32'h1);
        chk("ch0rd8.valid", 32'(valid), 32'h0);

        // Drain channel 1: 5..29, plus 0xAA when full channels are skipped.
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0, 8'h00, 4'h2);
            chk($sformatf("ch1rd%0d.dout", k), dout, 32'(5 + 4 * k) << 8);
        end
        step(1'b1, 1'b0, 8'h00, 4'h2);
`ifdef RR_DIST_SKIP_FULL_EN
        chk("ch1last.dout", dout, 32'h0000aa00);
        chk("ch1last.valid", 32'(valid), 32'h2);
`else
        chk("ch1last.rerr", 32'(rerr), 32'h2);
        chk("ch1last.dout", dout, 32'h0);
`endif

        // Reset mid-operation with five entries stored.
        step(1'b0, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 8'(8'hc0 + i), 4'h0);
        end
        chk("mid.ptr_pre", 32'(ptr), 32'h1);
        chk("mid.empty_pre", 32'(empty), 32'h0);
        step(1'b0, 1'b1, 8'h77, 4'hf);
        chk_all("midrst", '{1'b0, 1'b0, 8'h0, 4'h0, 32'h0, 4'h0, 4'h0,
                            1'b0, 4'h0, 4'hf, 2'd0});
        step(1'b1, 1'b0, 8'h00, 4'hf);
        chk("midrst.rd_rerr", 32'(rerr), 32'hf);
        chk("midrst.rd_valid", 32'(valid), 32'h0);
        chk("midrst.rd_dout", dout, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
